// File: rtl/dma_desc_sched_if.sv
// Descriptor push, streamer issue and completion signals between the DMA CSR
// block, the descriptor scheduler and the DMA streamer.
interface dma_desc_sched_if #(
    parameter int CHW     = 2,
    parameter int ADDR_W  = 32,
    parameter int BYTES_W = 32
);
    logic               push_valid;
    logic               push_ready;
    logic [CHW-1:0]     push_ch;
    logic [ADDR_W-1:0]  push_src;
    logic [ADDR_W-1:0]  push_dst;
    logic [BYTES_W-1:0] push_bytes;

    logic               issue_valid;
    logic               issue_ready;
    logic [CHW-1:0]     issue_ch;
    logic [ADDR_W-1:0]  issue_src;
    logic [ADDR_W-1:0]  issue_dst;
    logic [BYTES_W-1:0] issue_bytes;

    logic               done_valid;
    logic               done_err;

    // Scheduler view: accepts pushes, presents descriptors, receives completions.
    modport slave (
        input  push_valid, push_ch, push_src, push_dst, push_bytes,
        output push_ready,
        output issue_valid, issue_ch, issue_src, issue_dst, issue_bytes,
        input  issue_ready,
        input  done_valid, done_err
    );

    // CSR/streamer view: drives pushes, consumes descriptors, reports completions.
    modport master (
        output push_valid, push_ch, push_src, push_dst, push_bytes,
        input  push_ready,
        input  issue_valid, issue_ch, issue_src, issue_dst, issue_bytes,
        output issue_ready,
        output done_valid, done_err
    );
endinterface

// File: rtl/dma_desc_sched.sv
// Multi-channel DMA descriptor scheduler: per-channel circular descriptor
// queues, round-robin issue of one descriptor at a time to the streamer, and
// per-channel busy / level / sticky done and error interrupt status.
module dma_desc_sched #(
    parameter int  NUM_CH     = 4,
    parameter int  DESC_DEPTH = 4,
    parameter int  ADDR_W     = 32,
    parameter int  BYTES_W    = 32,
    localparam int CHW        = $clog2(NUM_CH > 1 ? NUM_CH : 2),
    localparam int LVLW       = $clog2(DESC_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dma_desc_sched_if.slave        bus,
    input  logic [NUM_CH-1:0]      ch_flush,
    output logic [NUM_CH-1:0]      ch_busy,
    output logic [NUM_CH*LVLW-1:0] ch_level,
    output logic [NUM_CH-1:0]      irq_done,
    output logic [NUM_CH-1:0]      irq_err,
    input  logic [NUM_CH-1:0]      irq_clr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CHW-1:0]     rr_ptr_r;
    logic [CHW-1:0]     rr_next_s;

    logic               issue_valid_r;
    logic [CHW-1:0]     issue_ch_r;
    logic [ADDR_W-1:0]  issue_src_r;
    logic [ADDR_W-1:0]  issue_dst_r;
    logic [BYTES_W-1:0] issue_bytes_r;

    logic               grant_found_s;
    logic [CHW-1:0]     grant_s;
    logic               grant_vld_s;
    logic               pop_s;
    logic [CHW:0]       cand_sum_s;
    logic [CHW-1:0]     cand_s;

    logic               push_ready_s;
    logic               push_fire_s;
    logic               push_zero_s;
    logic               push_q_s;
    logic               done_evt_s;

    logic [LVLW-1:0]    level_s      [NUM_CH];
    logic [ADDR_W-1:0]  head_src_s   [NUM_CH];
    logic [ADDR_W-1:0]  head_dst_s   [NUM_CH];
    logic [BYTES_W-1:0] head_bytes_s [NUM_CH];
    logic [NUM_CH-1:0]  eligible_s;
    logic [NUM_CH-1:0]  full_s;
    logic [NUM_CH-1:0]  done_set_s;
    logic [NUM_CH-1:0]  err_set_s;
    logic [(1<<CHW)-1:0] block_s;

    logic [NUM_CH-1:0]  irq_done_r;
    logic [NUM_CH-1:0]  irq_err_r;

    // Out-of-range channel codes are permanently blocked so push_ready can
    // index the full CHW-bit space directly.
    for (genvar g = 0; g < (1 << CHW); g++) begin : g_block
        if (g < NUM_CH) begin : g_real
            assign block_s[g] = full_s[g] | ch_flush[g];
        end else begin : g_pad
            assign block_s[g] = 1'b1;
        end
    end

    assign push_ready_s = ~block_s[bus.push_ch];
    assign push_fire_s  = bus.push_valid & push_ready_s;
    assign push_zero_s  = (bus.push_bytes == {BYTES_W{1'b0}});
    assign push_q_s     = push_fire_s & ~push_zero_s;
    assign done_evt_s   = (state_r == ST_WAIT) & bus.done_valid;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [LVLW-1:0]    wr_ptr_r;
        logic [LVLW-1:0]    rd_ptr_r;
        logic [ADDR_W-1:0]  src_mem_r   [DESC_DEPTH];
        logic [ADDR_W-1:0]  dst_mem_r   [DESC_DEPTH];
        logic [BYTES_W-1:0] bytes_mem_r [DESC_DEPTH];
        logic               is_issue_ch_s;
        logic               push_here_s;
        logic               pop_here_s;
        logic               keep_s;

        assign is_issue_ch_s = (issue_ch_r == CHW'(g));
        assign push_here_s   = push_q_s & (bus.push_ch == CHW'(g));
        assign pop_here_s    = pop_s & is_issue_ch_s;
        // The head currently presented to the streamer survives a flush.
        assign keep_s        = (state_r == ST_ISSUE) & is_issue_ch_s;

        // Queue pointers: flush collapses the queue to the presented head, pop advances the read side.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_r <= {LVLW{1'b0}};
                rd_ptr_r <= {LVLW{1'b0}};
            end else begin
                if (ch_flush[g]) begin
                    wr_ptr_r <= rd_ptr_r + LVLW'(keep_s);
                end else if (push_here_s) begin
                    wr_ptr_r <= wr_ptr_r + LVLW'(1);
                end else begin
                    wr_ptr_r <= wr_ptr_r;
                end
                if (pop_here_s) begin
                    rd_ptr_r <= rd_ptr_r + LVLW'(1);
                end else begin
                    rd_ptr_r <= rd_ptr_r;
                end
            end
        end

        // Descriptor storage; contents are only meaningful between the pointers.
        always_ff @(posedge clk) begin
            if (push_here_s) begin
                src_mem_r[wr_ptr_r[LVLW-2:0]]   <= bus.push_src;
                dst_mem_r[wr_ptr_r[LVLW-2:0]]   <= bus.push_dst;
                bytes_mem_r[wr_ptr_r[LVLW-2:0]] <= bus.push_bytes;
            end
        end

        assign level_s[g]      = wr_ptr_r - rd_ptr_r;
        assign head_src_s[g]   = src_mem_r[rd_ptr_r[LVLW-2:0]];
        assign head_dst_s[g]   = dst_mem_r[rd_ptr_r[LVLW-2:0]];
        assign head_bytes_s[g] = bytes_mem_r[rd_ptr_r[LVLW-2:0]];
        assign full_s[g]       = (level_s[g] == LVLW'(DESC_DEPTH));
        // A channel being flushed this cycle is not granted, so a flush never
        // races with a fresh grant of the entry it discards.
        assign eligible_s[g]   = (level_s[g] != {LVLW{1'b0}}) & ~ch_flush[g];
        assign ch_level[g*LVLW +: LVLW] = level_s[g];
        assign ch_busy[g]      = (level_s[g] != {LVLW{1'b0}}) | ((state_r != ST_IDLE) & is_issue_ch_s);
        assign done_set_s[g]   = done_evt_s & ~bus.done_err & is_issue_ch_s & (level_s[g] == {LVLW{1'b0}});
        assign err_set_s[g]    = (done_evt_s & bus.done_err & is_issue_ch_s)
                               | (push_fire_s & push_zero_s & (bus.push_ch == CHW'(g)));
    end

    // Round-robin search: first eligible channel at or after the RR pointer, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_s       = {CHW{1'b0}};
        cand_sum_s    = {(CHW+1){1'b0}};
        cand_s        = {CHW{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            cand_sum_s = {1'b0, rr_ptr_r} + (CHW+1)'(k);
            cand_s     = (cand_sum_s >= (CHW+1)'(NUM_CH)) ? CHW'(cand_sum_s - (CHW+1)'(NUM_CH))
                                                          : CHW'(cand_sum_s);
            if (!grant_found_s && eligible_s[cand_s]) begin
                grant_found_s = 1'b1;
                grant_s       = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    assign rr_next_s = (grant_s == CHW'(NUM_CH - 1)) ? {CHW{1'b0}} : (grant_s + CHW'(1));

    // FSM next state: grant in IDLE, pop on handshake in ISSUE, return on completion in WAIT.
    always_comb begin
        state_s     = state_r;
        grant_vld_s = 1'b0;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_found_s) begin
                    grant_vld_s = 1'b1;
                    state_s     = ST_ISSUE;
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.issue_ready) begin
                    pop_s   = 1'b1;
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (bus.done_valid) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Issue register: load the granted head, hold until handshake, advance RR pointer on grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid_r <= 1'b0;
            issue_ch_r    <= {CHW{1'b0}};
            issue_src_r   <= {ADDR_W{1'b0}};
            issue_dst_r   <= {ADDR_W{1'b0}};
            issue_bytes_r <= {BYTES_W{1'b0}};
            rr_ptr_r      <= {CHW{1'b0}};
        end else if (grant_vld_s) begin
            issue_valid_r <= 1'b1;
            issue_ch_r    <= grant_s;
            issue_src_r   <= head_src_s[grant_s];
            issue_dst_r   <= head_dst_s[grant_s];
            issue_bytes_r <= head_bytes_s[grant_s];
            rr_ptr_r      <= rr_next_s;
        end else if (pop_s) begin
            issue_valid_r <= 1'b0;
        end else begin
            issue_valid_r <= issue_valid_r;
        end
    end

    // Sticky interrupts: a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_done_r <= {NUM_CH{1'b0}};
            irq_err_r  <= {NUM_CH{1'b0}};
        end else begin
            irq_done_r <= (irq_done_r & ~irq_clr) | done_set_s;
            irq_err_r  <= (irq_err_r & ~irq_clr) | err_set_s;
        end
    end

    assign bus.push_ready  = push_ready_s;
    assign bus.issue_valid = issue_valid_r;
    assign bus.issue_ch    = issue_ch_r;
    assign bus.issue_src   = issue_src_r;
    assign bus.issue_dst   = issue_dst_r;
    assign bus.issue_bytes = issue_bytes_r;
    assign irq_done        = irq_done_r;
    assign irq_err         = irq_err_r;

endmodule

// File: tb/tb_dma_desc_sched.sv
// Directed self-checking bench for the DMA descriptor scheduler.
module tb_dma_desc_sched;
    localparam int NUM_CH = 4;
    localparam int LVLW   = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] ch_flush;
    logic [NUM_CH-1:0] ch_busy;
    logic [NUM_CH*LVLW-1:0] ch_level;
    logic [NUM_CH-1:0] irq_done;
    logic [NUM_CH-1:0] irq_err;
    logic [NUM_CH-1:0] irq_clr;

    int checks   = 0;
    int failures = 0;

    dma_desc_sched_if #(.CHW(2), .ADDR_W(32), .BYTES_W(32)) bus ();

    dma_desc_sched #(
        .NUM_CH(4), .DESC_DEPTH(4), .ADDR_W(32), .BYTES_W(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .ch_flush(ch_flush),
        .ch_busy(ch_busy),
        .ch_level(ch_level),
        .irq_done(irq_done),
        .irq_err(irq_err),
        .irq_clr(irq_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [1:0] ch, input logic [31:0] src,
                            input logic [31:0] dst, input logic [31:0] bytes);
        bus.push_valid = 1'b1;
        bus.push_ch    = ch;
        bus.push_src   = src;
        bus.push_dst   = dst;
        bus.push_bytes = bytes;
        tick();
        bus.push_valid = 1'b0;
    endtask

    task automatic wait_issue();
        for (int n = 0; n < 50 && !bus.issue_valid; n++) tick();
        check("issue_wait", bus.issue_valid, 1);
    endtask

    // Accept the presented descriptor, then complete it three cycles later.
    task automatic drain_one(input logic [1:0] exp_ch, input logic [31:0] exp_src,
                             input logic err, input logic [3:0] clr);
        wait_issue();
        check("drain_ch", bus.issue_ch, exp_ch);
        check("drain_src", bus.issue_src, exp_src);
        bus.issue_ready = 1'b1;
        tick();
        bus.issue_ready = 1'b0;
        check("drain_valid_drop", bus.issue_valid, 0);
        tick();
        tick();
        bus.done_valid = 1'b1;
        bus.done_err   = err;
        irq_clr        = clr;
        tick();
        bus.done_valid = 1'b0;
        bus.done_err   = 1'b0;
        irq_clr        = 4'h0;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.push_valid  = 1'b0;
        bus.push_ch     = 2'd0;
        bus.push_src    = 32'h0;
        bus.push_dst    = 32'h0;
        bus.push_bytes  = 32'h0;
        bus.issue_ready = 1'b0;
        bus.done_valid  = 1'b0;
        bus.done_err    = 1'b0;
        ch_flush        = 4'h0;
        irq_clr         = 4'h0;
        tick();
        tick();
        check("rst_issue_valid", bus.issue_valid, 0);
        check("rst_issue_src", bus.issue_src, 0);
        check("rst_busy", ch_busy, 0);
        check("rst_level", ch_level, 0);
        check("rst_irq", {irq_done, irq_err}, 0);
        rst_n = 1'b1;
        tick();

        // Single descriptor on ch1: two-edge latency, handshake, completion.
        bus.push_valid = 1'b1;
        bus.push_ch    = 2'd1;
        bus.push_src   = 32'h1000;
        bus.push_dst   = 32'h2000;
        bus.push_bytes = 32'h40;
        #1;
        check("t1_push_ready", bus.push_ready, 1);
        tick();
        bus.push_valid = 1'b0;
        check("t1_valid_early", bus.issue_valid, 0);
        check("t1_level", ch_level[5:3], 1);
        tick();
        check("t1_valid", bus.issue_valid, 1);
        check("t1_ch", bus.issue_ch, 1);
        check("t1_src", bus.issue_src, 32'h1000);
        check("t1_dst", bus.issue_dst, 32'h2000);
        check("t1_bytes", bus.issue_bytes, 32'h40);
        bus.issue_ready = 1'b1;
        tick();
        bus.issue_ready = 1'b0;
        check("t1_wait_busy", ch_busy[1], 1);
        check("t1_level_pop", ch_level[5:3], 0);
        tick();
        bus.done_valid = 1'b1;
        tick();
        bus.done_valid = 1'b0;
        check("t1_irq_done", irq_done, 4'b0010);
        check("t1_busy_clear", ch_busy[1], 0);
        check("t1_irq_err", irq_err, 0);

        // Fill ch0 to depth, refuse the fifth push, drain in order.
        irq_clr = 4'hF;
        tick();
        irq_clr = 4'h0;
        for (int k = 0; k < 4; k++) push_one(2'd0, 32'h100 + k, 32'h900 + k, 32'h10);
        bus.push_valid = 1'b1;
        bus.push_ch    = 2'd0;
        bus.push_src   = 32'h1FF;
        bus.push_bytes = 32'h10;
        #1;
        check("t2_full_ready", bus.push_ready, 0);
        check("t2_level_full", ch_level[2:0], 4);
        tick();
        bus.push_valid = 1'b0;
        check("t2_level_hold", ch_level[2:0], 4);
        for (int k = 0; k < 4; k++) begin
            drain_one(2'd0, 32'h100 + k, 1'b0, 4'h0);
            check("t2_irq_done", irq_done[0], (k == 3) ? 1'b1 : 1'b0);
        end

        // Round-robin across ch0, ch2, ch3.
        irq_clr = 4'hF;
        tick();
        irq_clr = 4'h0;
        push_one(2'd0, 32'h300, 32'h0, 32'h8);
        push_one(2'd2, 32'h301, 32'h0, 32'h8);
        push_one(2'd3, 32'h302, 32'h0, 32'h8);
        push_one(2'd0, 32'h303, 32'h0, 32'h8);
        push_one(2'd2, 32'h304, 32'h0, 32'h8);
        push_one(2'd3, 32'h305, 32'h0, 32'h8);
        drain_one(2'd0, 32'h300, 1'b0, 4'h0);
        drain_one(2'd2, 32'h301, 1'b0, 4'h0);
        drain_one(2'd3, 32'h302, 1'b0, 4'h0);
        drain_one(2'd0, 32'h303, 1'b0, 4'h0);
        drain_one(2'd2, 32'h304, 1'b0, 4'h0);
        drain_one(2'd3, 32'h305, 1'b0, 4'h0);
        check("t3_irq_done", irq_done, 4'b1101);

        // Error completion on ch2, then set-wins-over-clear.
        irq_clr = 4'hF;
        tick();
        irq_clr = 4'h0;
        push_one(2'd2, 32'h400, 32'h0, 32'h8);
        drain_one(2'd2, 32'h400, 1'b1, 4'h0);
        check("t4_irq_err", irq_err[2], 1);
        check("t4_irq_done", irq_done[2], 0);
        push_one(2'd2, 32'h401, 32'h0, 32'h8);
        drain_one(2'd2, 32'h401, 1'b1, 4'b0100);
        check("t4_set_wins", irq_err[2], 1);
        irq_clr = 4'b0100;
        tick();
        irq_clr = 4'h0;
        check("t4_clear", irq_err[2], 0);

        // Zero-length push on ch3: accepted, not queued, flags error.
        bus.push_valid = 1'b1;
        bus.push_ch    = 2'd3;
        bus.push_src   = 32'h500;
        bus.push_bytes = 32'h0;
        #1;
        check("t5_ready", bus.push_ready, 1);
        tick();
        bus.push_valid = 1'b0;
        check("t5_level", ch_level[11:9], 0);
        check("t5_irq_err", irq_err[3], 1);
        tick();
        tick();
        tick();
        check("t5_no_issue", bus.issue_valid, 0);
        check("t5_busy", ch_busy, 0);

        // Flush ch0 while its head is presented, then reset during WAIT.
        push_one(2'd0, 32'h600, 32'h0, 32'h8);
        push_one(2'd0, 32'h601, 32'h0, 32'h8);
        push_one(2'd0, 32'h602, 32'h0, 32'h8);
        check("t6_level3", ch_level[2:0], 3);
        check("t6_presented", bus.issue_src, 32'h600);
        ch_flush       = 4'b0001;
        bus.push_valid = 1'b1;
        bus.push_ch    = 2'd0;
        bus.push_src   = 32'h6FF;
        bus.push_bytes = 32'h8;
        #1;
        check("t6_flush_refuse", bus.push_ready, 0);
        tick();
        ch_flush       = 4'h0;
        bus.push_valid = 1'b0;
        check("t6_level_keep", ch_level[2:0], 1);
        check("t6_valid_hold", bus.issue_valid, 1);
        check("t6_src_hold", bus.issue_src, 32'h600);
        check("t6_ch_hold", bus.issue_ch, 0);
        bus.issue_ready = 1'b1;
        tick();
        bus.issue_ready = 1'b0;
        check("t6_level_empty", ch_level[2:0], 0);
        check("t6_wait_busy", ch_busy[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", bus.issue_valid, 0);
        check("t6_rst_src", bus.issue_src, 0);
        check("t6_rst_busy", ch_busy, 0);
        check("t6_rst_level", ch_level, 0);
        check("t6_rst_irq", {irq_done, irq_err}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dma_desc_sched.md
Name: dma_desc_sched

Overview:
Multi-channel descriptor scheduler for the Venus DMA. It replaces the fixed two-descriptor, single-channel setup with NUM_CH independent descriptor queues, each DESC_DEPTH deep. Queued descriptors are arbitrated round-robin into the single DMA streamer, one in flight at a time. The block also tracks per-channel busy, done and error status and interrupts. It sits between the DMA CSR block (push side) and the DMA streamer/FSM (issue side).

Parameters:
NUM_CH, 4, number of channels (1..16).
DESC_DEPTH, 4, descriptors per channel queue; power of 2, >=2.
ADDR_W, 32, source/destination address width.
BYTES_W, 32, byte-count width.
(Derived: CHW = $clog2(NUM_CH>1?NUM_CH:2); LVLW = $clog2(DESC_DEPTH)+1.)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
push_valid  in  1  descriptor push request
push_ready  out  1  push accepted this cycle when high with push_valid
push_ch  in  CHW  target channel
push_src  in  ADDR_W  source address
push_dst  in  ADDR_W  destination address
push_bytes  in  BYTES_W  transfer length in bytes
ch_flush  in  NUM_CH  per-channel queue flush pulse
issue_valid  out  1  descriptor presented to streamer
issue_ready  in  1  streamer accepts descriptor
issue_ch  out  CHW  channel of presented descriptor
issue_src  out  ADDR_W  source address
issue_dst  out  ADDR_W  destination address
issue_bytes  out  BYTES_W  length
done_valid  in  1  streamer completion pulse for the in-flight descriptor
done_err  in  1  completion carried an error (AXI RD/WR, unaligned, narrow-cross)
ch_busy  out  NUM_CH  queue non-empty or descriptor in flight
ch_level  out  NUM_CH*LVLW  per-channel queue occupancy, channel i at [i*LVLW +: LVLW]
irq_done  out  NUM_CH  sticky: channel drained after completion
irq_err  out  NUM_CH  sticky: error or zero-length push on channel
irq_clr  in  NUM_CH  clears both sticky bits of channel i

Behaviour:
- Reset (async assert, sync deassert): queues empty, FSM IDLE, RR pointer = 0, issue_valid=0, issue_* = 0, irq_*=0, ch_busy=0, ch_level=0.
- push_ready = 0 when the target queue is full, or ch_flush[push_ch] is high; otherwise 1. push_ready is combinational from push_ch and the flush/full state.
- A push with push_bytes==0 is accepted but not queued. It sets irq_err[push_ch] next cycle.
- Accepted pushes appear in ch_level the next cycle. Each queue is a circular buffer; pointers are LVLW wide and wrap naturally.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any queue is non-empty, grant the first non-empty channel at or after the RR pointer, wrapping. Register the head into issue_*, set issue_valid=1 and go to ISSUE. The RR pointer advances to grant+1 mod NUM_CH.
- Latency: push at edge N yields issue_valid at edge N+2, minimum.
- ISSUE: issue_valid and issue_* stay stable until issue_ready. On the handshake, pop the head, drop issue_valid and go to WAIT.
- WAIT: on done_valid, go to IDLE. If done_err, set irq_err[ch]. Else, if that channel's queue is empty, set irq_done[ch].
- done_valid outside WAIT is ignored.
- ch_flush[i]: next cycle, the queue holds only the entry currently presented in ISSUE for channel i, if any; otherwise the queue is empty. Flush does not affect the in-flight descriptor, and does not set irq bits.
- ch_busy[i] = (level_i != 0) | (state != IDLE and issue_ch == i).
- irq set and irq_clr in the same cycle: set wins.
- Simultaneous push and pop on the same channel: both occur, and level is unchanged.
- Reset mid-transfer discards all queued and in-flight state. The streamer is reset by the same rst_n.

Test Plan:
- Reset, push ch1 {src=0x1000,dst=0x2000,bytes=0x40} -> issue_valid at cycle +2 with those values, issue_ch=1. issue_ready=1 -> WAIT. done_valid -> irq_done[1]=1, ch_busy[1]=0.
- Fill ch0 with 4 descriptors, 5th push -> push_ready=0, ch_level[0]=4. Drain with issue_ready=1 and done after 3 cycles -> descriptors issued in order, irq_done[0] only after the 4th done.
- Two descriptors each in ch0, ch2, ch3 -> issue order 0,2,3,0,2,3.
- done_err=1 on ch2 -> irq_err[2]=1, irq_done[2] unchanged. irq_clr[2] on the same cycle as a new error -> bit stays 1.
- Push bytes=0 to ch3 -> push_ready=1, ch_level[3]=0, irq_err[3]=1, no issue.
- ch0 holding 3, in ISSUE on ch0 with issue_ready=0, pulse ch_flush[0] -> ch_level[0]=1, issue_* unchanged, push to ch0 that cycle refused. Assert rst_n=0 in WAIT -> all outputs 0 immediately.
